// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl front-end of the 32-word data memory.
// Optional feature macro: MEM_CTRL_STATS_EN (activity counters on mem_ctrl).
package mem_ctrl_pkg;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 5;
  localparam int BE_W       = DATA_W / 8;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    for (int i = 0; i < BE_W; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response channel between a requester (master) and mem_ctrl (slave).
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_be_merge.sv
// Byte-lane merge for read-modify-write: enabled lanes from wdata, the rest from old_data.
module mem_be_merge
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] old_data,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] merged
);

  logic [DATA_W-1:0] mask;

  assign mask   = be_to_mask(be);
  assign merged = (wdata & mask) | (old_data & ~mask);

endmodule

// File: rtl/mem_ctrl.sv
// Load/store sequencer in front of the single-port data memory (one-cycle negedge read).
// Define MEM_CTRL_STATS_EN to add saturating stat_rd/stat_wr/stat_err counters.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mem_ctrl_if.slave         bus,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_rd,
  output logic [STAT_W-1:0] stat_wr,
  output logic [STAT_W-1:0] stat_err
`endif
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] merged;
  logic              in_range;

  assign in_range = (bus.req_addr[ADDR_W-1:DEPTH_LOG2] == '0);

  mem_be_merge u_merge (
    .wdata    (wdata_q),
    .old_data (mem_dout),
    .be       (be_q),
    .merged   (merged)
  );

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (!in_range) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (!bus.req_write) begin
            state_d    = RD;
            mem_addr_d = bus.req_addr;
          end else if (bus.req_be == '1) begin
            state_d    = WR;
            mem_addr_d = bus.req_addr;
            mem_din_d  = bus.req_wdata;
          end else if (bus.req_be == '0) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d    = RD;
            mem_addr_d = bus.req_addr;
          end
        end
      end
      RD: begin
        if (write_q) begin
          state_d   = WR;
          mem_din_d = merged;
        end else begin
          state_d = RESP;
          rdata_d = mem_dout;
          err_d   = 1'b0;
        end
      end
      WR: begin
        state_d = RESP;
        rdata_d = mem_din_q;
        err_d   = 1'b0;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The strobe is registered, so it follows the state being entered.
    mem_write_d = (state_d == WR);
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    mem_write      = mem_write_q;
    mem_addr       = mem_addr_q;
    mem_din        = mem_din_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  // NOTE: the latched request payload is left out of reset; it is always loaded in IDLE before use.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

`ifdef MEM_CTRL_STATS_EN
  logic [STAT_W-1:0] stat_rd_q, stat_rd_d;
  logic [STAT_W-1:0] stat_wr_q, stat_wr_d;
  logic [STAT_W-1:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (state_q == RD && !write_q && stat_rd_q != '1) stat_rd_d = stat_rd_q + 1'b1;
    if (state_q == WR && stat_wr_q != '1)              stat_wr_d = stat_wr_q + 1'b1;
    if (state_q == IDLE && bus.req_valid && !in_range && stat_err_q != '1)
      stat_err_d = stat_err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_rd  = stat_rd_q;
  assign stat_wr  = stat_wr_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: negedge-updated 32-word memory plus a byte-lane reference model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] ref_mem [32];
  int                n_vec;
  int                n_err;
  int                e_rd, e_wr, e_err;
`ifdef MEM_CTRL_STATS_EN
  logic [STAT_W-1:0] stat_rd, stat_wr, stat_err;
`endif

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
`ifdef MEM_CTRL_STATS_EN
    ,
    .stat_rd   (stat_rd),
    .stat_wr   (stat_wr),
    .stat_err  (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_addr[4:0]] <= mem_din;
    end
    mem_dout <= mem[mem_addr[4:0]];
  end

  // Full transaction: model prediction, drive, latency/strobe count, hold, handshake.
  task automatic do_req(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input string name);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat, exp_wrc, lat, wr_cnt, guard;
    exp_err   = (addr >= 32);
    exp_rdata = '0;
    exp_wrc   = 0;
    if (exp_err) begin
      exp_lat = 1;
      e_err++;
    end else if (!wr) begin
      exp_rdata = ref_mem[addr[4:0]];
      exp_lat   = 2;
      e_rd++;
    end else if (be == 4'h0) begin
      exp_lat = 1;
    end else begin
      exp_rdata = ref_mem[addr[4:0]];
      for (int l = 0; l < 4; l++) if (be[l]) exp_rdata[8*l +: 8] = wdata[8*l +: 8];
      ref_mem[addr[4:0]] = exp_rdata;
      exp_wrc = 1;
      exp_lat = (be == 4'hF) ? 2 : 3;
      e_wr++;
    end

    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", name, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat    = 1;
    wr_cnt = 0;
    while (!bus.resp_valid && lat < 10) begin
      if (mem_write) wr_cnt++;
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (bus.resp_rdata !== exp_rdata || bus.resp_err !== exp_err) begin
      n_err++;
      $display("FAIL %s resp: rdata=%h err=%b required rdata=%h err=%b",
               name, bus.resp_rdata, bus.resp_err, exp_rdata, exp_err);
    end
    n_vec++;
    if (wr_cnt != exp_wrc) begin
      n_err++;
      $display("FAIL %s mem_write_cycles: got %0d required %0d", name, wr_cnt, exp_wrc);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_vec++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp_rdata || bus.resp_err !== exp_err ||
          bus.req_ready !== 1'b0 || mem_write !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b mw=%b required 1 %h %b 0 0",
                 name, h, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready,
                 mem_write, exp_rdata, exp_err);
      end
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s handshake: resp_valid=%b req_ready=%b required 0 1",
               name, bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== '0 ||
        mem_write !== 1'b0 || mem_addr !== '0 || mem_din !== '0 || bus.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: valid=%b err=%b rdata=%h mw=%b maddr=%h mdin=%h ready=%b required 0 0 0 0 0 0 1",
               name, bus.resp_valid, bus.resp_err, bus.resp_rdata, mem_write, mem_addr,
               mem_din, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    clr   = 1'b0;
    e_rd  = 0;
    e_wr  = 0;
    e_err = 0;
    @(negedge clk);
  endtask

  task automatic test_full_store_load();
    do_req(1'b1, 24'd3, 32'hDEADBEEF, 4'hF, 0, "store_full");
    do_req(1'b0, 24'd3, 32'h0, 4'h0, 0, "load_back");
  endtask

  task automatic test_partial_store();
    do_req(1'b1, 24'd5, 32'h11223344, 4'hF, 0, "preload5");
    do_req(1'b1, 24'd5, 32'hAABBCCDD, 4'b0101, 1, "store_partial");
    n_vec++;
    if (mem[5] !== 32'h11BB33DD) begin
      n_err++;
      $display("FAIL mem5_after_rmw: got %h required %h", mem[5], 32'h11BB33DD);
    end
  endtask

  task automatic test_error();
    do_req(1'b0, 24'd32, 32'h0, 4'h0, 0, "load_addr32");
    do_req(1'b0, 24'h800005, 32'h0, 4'h0, 0, "load_high_bits");
    do_req(1'b1, 24'h000020, 32'hFFFFFFFF, 4'hF, 0, "store_oor");
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] held_addr;
    do_req(1'b1, 24'd9, 32'hCAFEF00D, 4'hF, 0, "bp_preload");
    held_addr = mem_addr;
    do_req(1'b0, 24'd9, 32'h0, 4'h0, 10, "bp_load");
    n_vec++;
    if (mem_addr !== held_addr) begin
      n_err++;
      $display("FAIL bp_mem_addr_hold: got %h required %h", mem_addr, held_addr);
    end
  endtask

  task automatic test_be_zero();
    do_req(1'b1, 24'd2, 32'h5, 4'hF, 0, "preload2");
    do_req(1'b1, 24'd2, 32'hFFFF0000, 4'h0, 0, "store_be0");
    n_vec++;
    if (mem[2] !== 32'h5) begin
      n_err++;
      $display("FAIL mem2_be0: got %h required %h", mem[2], 32'h5);
    end
    do_req(1'b0, 24'd2, 32'h0, 4'h0, 0, "load2");
  endtask

  task automatic test_reset_mid_rmw();
    do_req(1'b1, 24'd7, 32'h12345678, 4'hF, 0, "preload7");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 24'd7;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_be    = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_rmw");
    rst_n = 1'b1;
    e_rd  = 0;
    e_wr  = 0;
    e_err = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (mem[7] !== 32'h12345678) begin
      n_err++;
      $display("FAIL mem7_after_abort: got %h required %h", mem[7], 32'h12345678);
    end
    do_req(1'b0, 24'd7, 32'h0, 4'h0, 0, "load7");
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    int                sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = ADDR_W'(32 + $urandom_range(0, 31));
      else if (sel == 1) addr = (ADDR_W'($urandom_range(1, 255)) << 16) | ADDR_W'($urandom_range(0, 31));
      else               addr = ADDR_W'($urandom_range(0, 31));
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
      do_req(1'($urandom), addr, $urandom, be, $urandom_range(0, 3), "random");
    end
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (mem[i] !== ref_mem[i]) begin
        n_err++;
        $display("FAIL mem_final[%0d]: got %h required %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

`ifdef MEM_CTRL_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e_rd  = 0;
    e_wr  = 0;
    e_err = 0;
    do_req(1'b1, 24'd1, 32'h01020304, 4'hF, 0, "st_store1");
    do_req(1'b1, 24'd1, 32'hA0B0C0D0, 4'b1000, 0, "st_store2");
    do_req(1'b0, 24'd1, 32'h0, 4'h0, 0, "st_load1");
    do_req(1'b0, 24'd3, 32'h0, 4'h0, 0, "st_load2");
    do_req(1'b0, 24'd5, 32'h0, 4'h0, 0, "st_load3");
    do_req(1'b0, 24'd40, 32'h0, 4'h0, 0, "st_err");
    n_vec++;
    if (stat_rd !== 16'(e_rd) || stat_wr !== 16'(e_wr) || stat_err !== 16'(e_err)) begin
      n_err++;
      $display("FAIL stats: rd=%0d wr=%0d err=%0d required %0d %0d %0d",
               stat_rd, stat_wr, stat_err, e_rd, e_wr, e_err);
    end
  endtask
`endif

  initial begin
    n_vec          = 0;
    n_err          = 0;
    clr            = 1'b1;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_be     = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    test_reset();
    test_full_store_load();
    test_partial_store();
    test_error();
    test_backpressure();
    test_be_zero();
    test_reset_mid_rmw();
    test_random();
`ifdef MEM_CTRL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
